// File: rtl/slurm32_mem_arbiter.sv
// slurm32_mem_arbiter: shares the 32-bit memory bus between instruction fetch and load/store,
// giving load/store priority while bounding how long fetch can be starved.
module slurm32_mem_arbiter #(
   parameter int ADDRESS_BITS = 32,
   parameter int BITS = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                    CLK,
   input  logic                    RSTb,
   input  logic                    fetch_req,
   input  logic [ADDRESS_BITS-1:0] fetch_addr,
   input  logic                    fetch_flush,
   output logic                    fetch_valid,
   output logic [BITS-1:0]         fetch_data,
   input  logic                    ls_load,
   input  logic                    ls_store,
   input  logic [ADDRESS_BITS-1:0] ls_addr,
   input  logic [BITS-1:0]         ls_wdata,
   input  logic [3:0]              ls_mask,
   output logic                    ls_valid,
   output logic [BITS-1:0]         ls_rdata,
   output logic                    ls_stall,
   output logic                    mem_req,
   output logic                    mem_wr,
   output logic [ADDRESS_BITS-1:0] mem_addr,
   output logic [BITS-1:0]         mem_wdata,
   output logic [3:0]              mem_mask,
   input  logic                    mem_ack,
   input  logic                    mem_rvalid,
   input  logic [BITS-1:0]         mem_rdata
);

   typedef enum logic [2:0] {IDLE, LS_ACK, LS_DATA, F_ACK, F_DATA} state_t;

   localparam logic [ADDRESS_BITS-1:0] WORD_MASK = ~ADDRESS_BITS'(3);

   state_t state, state_n;
   logic [3:0] streak, streak_n;
   logic flush_q, flush_n;
   logic mem_req_n, mem_wr_n, ls_valid_n, fetch_valid_n;
   logic [ADDRESS_BITS-1:0] mem_addr_n;
   logic [BITS-1:0] mem_wdata_n, ls_rdata_n, fetch_data_n;
   logic [3:0] mem_mask_n;
   logic ls_any, ls_go, f_go;

   // A load/store in its own valid cycle cannot be re-granted, but still holds off fetch
   assign ls_any = ls_load | ls_store;
   assign ls_go = ls_any & ~ls_valid;
   assign f_go = fetch_req & ~fetch_valid & ~fetch_flush & (~ls_any | streak == 4'(STARVE_LIMIT));
   assign ls_stall = ls_any & ~ls_valid;

   always_comb begin
      state_n = state;
      streak_n = streak;
      flush_n = flush_q;
      mem_req_n = mem_req;
      mem_wr_n = mem_wr;
      mem_addr_n = mem_addr;
      mem_wdata_n = mem_wdata;
      mem_mask_n = mem_mask;
      ls_valid_n = 1'b0;
      fetch_valid_n = 1'b0;
      ls_rdata_n = ls_rdata;
      fetch_data_n = fetch_data;
      case (state)
         IDLE: begin
            flush_n = 1'b0;
            if (f_go) begin
               state_n = F_ACK;
               mem_req_n = 1'b1;
               mem_wr_n = 1'b0;
               mem_addr_n = fetch_addr & WORD_MASK;
               mem_mask_n = 4'hF;
               streak_n = 4'd0;
            end else if (ls_go) begin
               state_n = LS_ACK;
               mem_req_n = 1'b1;
               mem_wr_n = ls_store;
               mem_addr_n = ls_addr & WORD_MASK;
               mem_wdata_n = ls_wdata;
               mem_mask_n = ls_store ? ls_mask : 4'hF;
               streak_n = ~fetch_req ? 4'd0 : streak == 4'(STARVE_LIMIT) ? streak : streak + 4'd1;
            end
         end
         LS_ACK: if (mem_ack) begin
            mem_req_n = 1'b0;
            mem_wr_n = 1'b0;
            ls_valid_n = mem_wr;
            state_n = mem_wr ? IDLE : LS_DATA;
         end
         LS_DATA: if (mem_rvalid) begin
            ls_rdata_n = mem_rdata;
            ls_valid_n = 1'b1;
            state_n = IDLE;
         end
         F_ACK: begin
            flush_n = flush_q | fetch_flush;
            if (mem_ack) begin
               mem_req_n = 1'b0;
               mem_wr_n = 1'b0;
               state_n = F_DATA;
            end
         end
         F_DATA: begin
            flush_n = flush_q | fetch_flush;
            if (mem_rvalid) begin
               fetch_data_n = mem_rdata;
               fetch_valid_n = ~(flush_q | fetch_flush);
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RSTb) begin
         state <= IDLE;
         streak <= 4'd0;
         flush_q <= 1'b0;
         mem_req <= 1'b0;
         mem_wr <= 1'b0;
         mem_addr <= '0;
         mem_wdata <= '0;
         mem_mask <= 4'd0;
         ls_valid <= 1'b0;
         fetch_valid <= 1'b0;
         ls_rdata <= '0;
         fetch_data <= '0;
      end else begin
         state <= state_n;
         streak <= streak_n;
         flush_q <= flush_n;
         mem_req <= mem_req_n;
         mem_wr <= mem_wr_n;
         mem_addr <= mem_addr_n;
         mem_wdata <= mem_wdata_n;
         mem_mask <= mem_mask_n;
         ls_valid <= ls_valid_n;
         fetch_valid <= fetch_valid_n;
         ls_rdata <= ls_rdata_n;
         fetch_data <= fetch_data_n;
      end
   end

endmodule

// File: tb/tb_slurm32_mem_arbiter.sv
// tb_slurm32_mem_arbiter: directed checks of grant order, handshake timing, flush and reset.
module tb_slurm32_mem_arbiter;

   logic CLK = 1'b0, RSTb = 1'b0;
   logic fetch_req = 0, fetch_flush = 0, ls_load = 0, ls_store = 0;
   logic [31:0] fetch_addr = 0, ls_addr = 0, ls_wdata = 0, mem_rdata = 0;
   logic [3:0] ls_mask = 0;
   logic fetch_valid, ls_valid, ls_stall, mem_req, mem_wr, mem_ack, mem_rvalid;
   logic [31:0] fetch_data, ls_rdata, mem_addr, mem_wdata;
   logic [3:0] mem_mask;

   logic auto_en = 1'b1, s_ack = 0, s_rv = 0, m_ack = 0, m_rv = 0;
   int ack_delay = 0;
   bit grants[$];
   int checks = 0, failures = 0;

   always #5 CLK = ~CLK;

   assign mem_ack = auto_en ? s_ack : m_ack;
   assign mem_rvalid = auto_en ? s_rv : m_rv;

   slurm32_mem_arbiter dut (
      .CLK(CLK), .RSTb(RSTb),
      .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_flush(fetch_flush),
      .fetch_valid(fetch_valid), .fetch_data(fetch_data),
      .ls_load(ls_load), .ls_store(ls_store), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_mask(ls_mask), .ls_valid(ls_valid), .ls_rdata(ls_rdata), .ls_stall(ls_stall),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_mask(mem_mask), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_flags"}, 32'({mem_req, mem_wr, ls_valid, fetch_valid, ls_stall, mem_mask}), 0);
      check({tag, "_addr"}, mem_addr, 0);
      check({tag, "_wdata"}, mem_wdata, 0);
      check({tag, "_ls_rdata"}, ls_rdata, 0);
      check({tag, "_fetch_data"}, fetch_data, 0);
   endtask

   // Bus slave: acks after ack_delay waiting cycles, returns read data the cycle after ack
   initial begin
      int cnt = 0;
      bit pend = 0;
      forever begin
         @(negedge CLK);
         s_rv = pend;
         pend = 0;
         s_ack = 0;
         if (mem_req && RSTb) begin
            if (cnt == ack_delay) begin
               s_ack = 1;
               cnt = 0;
               pend = !mem_wr;
               grants.push_back(mem_addr[12]);
            end else cnt++;
         end
      end
   end

   initial begin
      bit pl, pf, lsd, fd;
      int viol;
      bit exp_g[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
      repeat (3) @(negedge CLK);
      check_zero("reset");
      RSTb = 1;

      mem_rdata = 32'hDEADBEEF; ls_load = 1; ls_addr = 32'h2007;
      #1 check("t1_stall_c0", 32'(ls_stall), 1);
      @(negedge CLK);
      check("t1_req_c1", 32'({mem_req, mem_wr, mem_mask}), 32'b10_1111);
      check("t1_addr", mem_addr, 32'h2004);
      check("t1_stall_c1", 32'(ls_stall), 1);
      @(negedge CLK);
      check("t1_c2", 32'({mem_req, ls_valid, ls_stall}), 32'b001);
      @(negedge CLK);
      check("t1_valid_c3", 32'({ls_valid, ls_stall}), 32'b10);
      check("t1_rdata", ls_rdata, 32'hDEADBEEF);
      ls_load = 0;
      @(negedge CLK);
      check("t1_valid_c4", 32'(ls_valid), 0);

      ack_delay = 3; ls_store = 1; ls_addr = 32'h103; ls_mask = 4'b0010; ls_wdata = 32'hCAFEF00D;
      for (int c = 1; c <= 4; c++) begin
         @(negedge CLK);
         check("t2_hold_flags", 32'({mem_req, mem_wr, ls_valid, mem_mask}), 32'b110_0010);
         check("t2_hold_addr", mem_addr, 32'h100);
         check("t2_hold_wdata", mem_wdata, 32'hCAFEF00D);
      end
      @(negedge CLK);
      check("t2_done", 32'({ls_valid, mem_req, mem_wr}), 32'b100);
      ls_store = 0; ack_delay = 0;
      @(negedge CLK);

      grants.delete(); viol = 0; pl = 0; pf = 0;
      fetch_req = 1; fetch_addr = 32'h1000; ls_load = 1; ls_addr = 32'h2000; mem_rdata = 32'h11112222;
      repeat (60) begin
         @(negedge CLK);
         if (pl && mem_req && !mem_addr[12]) viol++;
         if (pf && mem_req && mem_addr[12]) viol++;
         pl = ls_valid; pf = fetch_valid;
      end
      fetch_req = 0; ls_load = 0;
      check("t3_regrant", viol, 0);
      check("t3_ngrants", 32'(grants.size() >= 10), 1);
      for (int i = 0; i < 10; i++)
         check("t3_order", i < grants.size() ? 32'(grants[i]) : 2, 32'(exp_g[i]));
      repeat (8) @(negedge CLK);

      for (int fc = 1; fc <= 2; fc++) begin
         mem_rdata = 32'h0BAD0BAD; fetch_req = 1; fetch_addr = 32'h1000;
         @(negedge CLK);
         fetch_flush = (fc == 1);
         check("t4_req", 32'(mem_req), 1);
         check("t4_addr", mem_addr, 32'h1000);
         @(negedge CLK);
         fetch_flush = (fc == 2);
         @(negedge CLK);
         fetch_flush = 0;
         check("t4_flushed", 32'(fetch_valid), 0);
         fetch_addr = 32'h1040; mem_rdata = 32'h600DF00D;
         @(negedge CLK);
         check("t4_refetch_req", 32'(mem_req), 1);
         check("t4_refetch_addr", mem_addr, 32'h1040);
         repeat (2) @(negedge CLK);
         check("t4_valid", 32'(fetch_valid), 1);
         check("t4_data", fetch_data, 32'h600DF00D);
         fetch_req = 0;
         @(negedge CLK);
         check("t4_valid_off", 32'(fetch_valid), 0);
      end

      grants.delete(); lsd = 0; fd = 0;
      ls_load = 1; ls_addr = 32'h2000; fetch_req = 1; fetch_addr = 32'h1000;
      for (int c = 0; c < 20 && !(lsd && fd); c++) begin
         @(negedge CLK);
         if (ls_valid) begin ls_load = 0; lsd = 1; end
         if (fetch_valid) begin fetch_req = 0; fd = 1; end
      end
      check("t5_done", 32'({lsd, fd}), 3);
      check("t5_ngrants", grants.size(), 2);
      check("t5_first_ls", grants.size() > 0 ? 32'(grants[0]) : 2, 0);
      check("t5_then_fetch", grants.size() > 1 ? 32'(grants[1]) : 2, 1);

      auto_en = 0;
      ls_load = 1; ls_addr = 32'h2000;
      @(negedge CLK);
      check("t6_req", 32'(mem_req), 1);
      m_ack = 1;
      @(negedge CLK);
      m_ack = 0;
      check("t6_in_data", 32'(mem_req), 0);
      RSTb = 0; ls_load = 0;
      @(negedge CLK);
      check_zero("t6_rst");
      RSTb = 1; m_rv = 1; mem_rdata = 32'h12345678;
      @(negedge CLK);
      m_rv = 0;
      check("t6_late_rv", 32'({ls_valid, fetch_valid, mem_req}), 0);
      check("t6_rdata", ls_rdata, 0);
      @(negedge CLK);
      check("t6_quiet", 32'({ls_valid, fetch_valid, mem_req}), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/slurm32_mem_arbiter.md
Name: slurm32_mem_arbiter

Overview:
Arbitrates the single 32-bit memory bus between the instruction-fetch port and the execute stage's load/store port (load_memory / store_memory / load_store_address / memory_out / memory_mask). It sequences each access through a request/accept/read-data handshake and stalls the pipeline while a load/store is outstanding. Load/store has priority over fetch, with a bounded-starvation guarantee for fetch. A fetch flush on branch (load_pc) discards the in-flight fetch result.

Parameters:
ADDRESS_BITS, 32, width of byte addresses
BITS, 32, data width
STARVE_LIMIT, 4, max consecutive load/store grants while fetch is waiting (range 1..15)

Ports:
CLK  input  1  clock
RSTb  input  1  reset, synchronous, active-low
fetch_req  input  1  fetch request; held until fetch_valid or fetch_flush
fetch_addr  input  ADDRESS_BITS  fetch byte address
fetch_flush  input  1  discard any pending/in-flight fetch (branch taken)
fetch_valid  output  1  one-cycle pulse: fetch_data valid
fetch_data  output  BITS  fetched word
ls_load  input  1  load request from execute; held until ls_valid
ls_store  input  1  store request from execute; held until ls_valid
ls_addr  input  ADDRESS_BITS  load/store byte address
ls_wdata  input  BITS  store data
ls_mask  input  4  store byte-lane enables
ls_valid  output  1  one-cycle pulse: load data valid / store complete
ls_rdata  output  BITS  loaded word (raw; lane extraction downstream)
ls_stall  output  1  pipeline stall
mem_req  output  1  bus request
mem_wr  output  1  1 = write
mem_addr  output  ADDRESS_BITS  word-aligned address
mem_wdata  output  BITS  write data
mem_mask  output  4  byte enables
mem_ack  input  1  bus accepts the request in a cycle when mem_req=1
mem_rvalid  input  1  read data valid
mem_rdata  input  BITS  read data

Behaviour:
- Reset: state IDLE; all outputs 0; streak counter 0; flush flag 0. Reset mid-transaction abandons it; the bus slave shares RSTb.
- States: IDLE, LS_ACK, LS_DATA, F_ACK, F_DATA.
- IDLE grant decision:
  - A requester whose valid pulse is high this cycle is masked.
  - ls = ls_load|ls_store; if both are set, store wins.
  - If fetch_req & ~fetch_flush & (~ls or streak==STARVE_LIMIT) -> grant fetch; else if ls -> grant ls; else stay IDLE.
- Grant actions (registered, take effect next cycle):
  - mem_req<=1.
  - mem_addr<={addr[ADDRESS_BITS-1:2],2'b00}.
  - ls grant: mem_wr<=ls_store, mem_wdata<=ls_wdata, mem_mask<=ls_mask (4'hF for loads); go to LS_ACK.
  - fetch grant: mem_wr<=0, mask 4'hF; go to F_ACK.
- Streak counter:
  - On ls grant: increment (saturating) if fetch_req, else clear.
  - On fetch grant: clear.
- *_ACK states: hold all mem_* stable until mem_ack.
  - On ack: mem_req<=0, mem_wr<=0.
  - Store: ls_valid<=1 and go to IDLE.
  - Read: go to *_DATA.
- *_DATA states:
  - On mem_rvalid: capture mem_rdata into ls_rdata/fetch_data and pulse the matching valid next cycle; go to IDLE.
  - fetch_valid is suppressed if the flush flag is set.
  - Data outputs hold their value until the next capture.
- Flush:
  - fetch_flush in F_ACK/F_DATA sets the flush flag.
  - The bus transaction still completes; the flag clears on return to IDLE.
  - fetch_flush in IDLE only blocks that cycle's fetch grant.
- ls_stall = (ls_load|ls_store) & ~ls_valid, combinational.
- Minimum latency:
  - Load: request seen in IDLE cycle 0, mem_req cycle 1, ack cycle 1, rvalid cycle 2, ls_valid cycle 3.
  - Store: ls_valid cycle 2.
- Only one bus transaction is outstanding at a time; mem_rvalid outside a *_DATA state is ignored.

Test Plan:
- Single load, ack immediate, rvalid one cycle later with 32'hDEADBEEF -> mem_addr=ls_addr&~3, ls_valid pulses cycle 3, ls_rdata=32'hDEADBEEF, ls_stall high cycles 0-2.
- Store ls_addr=32'h103, ls_mask=4'b0010, ack delayed 3 cycles -> mem_addr=32'h100, mem_wr/mask/wdata stable while waiting, ls_valid one cycle after ack.
- fetch_req held continuously with back-to-back loads, STARVE_LIMIT=4 -> grants L,L,L,L,F,L...; no requester is re-granted in its own valid cycle.
- fetch_flush asserted in F_DATA -> transaction completes, fetch_valid stays 0, next fetch is granted from IDLE.
- Simultaneous ls_load and fetch_req with streak 0 -> load is granted first, fetch follows.
- RSTb low while in LS_DATA -> next cycle all outputs 0 and state IDLE; a late mem_rvalid produces no valid pulse.
